// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// ---------------
// Sequencing controller for the bit-serial adder datapath. A start request in
// IDLE captures two WIDTH-bit operands. The operands are then added one bit
// per clock, LSB first, through a single registered carry. After WIDTH
// bit-cycles the registered sum and carry-out are presented and done pulses
// for one cycle.
//
// Optional feature macro: SERIAL_SUB_EN
//   When defined, a 'sub' port exists. With sub=1 the block computes a-b
//   (two's complement: ~b with carry-in 1), and cout=1 means "no borrow".
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset, clears all state
//   start  in   begin an operation (sampled only in IDLE)
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   sub    in   subtract select (only with SERIAL_SUB_EN)
//   busy   out  high in SHIFT and DONE
//   done   out  one-cycle pulse while in DONE
//   sum    out  WIDTH-bit result, held until the next accept
//   cout   out  final carry, held together with sum
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic [1:0]       fa_out;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

  // One-bit full adder: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

`ifdef SERIAL_SUB_EN
  // Subtraction is a + ~b + 1, so only the loaded B and the carry-in change.
  assign b_load   = sub ? ~b : b;
  assign cin_load = sub;
`else
  assign b_load   = b;
  assign cin_load = 1'b0;
`endif

  assign last_bit = (cnt == LAST);
  assign fa_out   = full_add(sa[0], sb[0], carry);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load on accept, then one bit per edge. The counter holds at WIDTH-1 on
  // the final bit so it never wraps; it is reloaded on every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b_load;
            carry <= cin_load;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
          end
        end
        SHIFT: begin
          carry <= fa_out[1];
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sum   <= {fa_out[0], sum[WIDTH-1:1]};
          if (last_bit) cout <= fa_out[1];
          else          cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// ------------------
// Randomized self-checking bench for serial_add_ctrl (WIDTH = 8). Expected
// results come from plain integer arithmetic on the operands; expected timing
// comes from the documented latency (WIDTH cycles accept-to-done) and
// throughput (WIDTH+2 cycles per operation with start held).
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {cout, sum} of a+b, or of a-b as a + ~b + 1 when s=1.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   r = {1'b0, x} + {1'b0, y};
    return r;
  endfunction

  // One operation from IDLE. Inputs are scrambled after the accept edge; a
  // stray start is pulsed at cycle ign of SHIFT (ign < 0 disables it).
  task automatic do_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic os, input int ign);
    logic [W:0] exp;
    int cyc;
    exp = model(oa, ob, os);
    @(negedge clk);
    a = oa; b = ob; sub = os; start = 1'b1;
    @(negedge clk);
    chk({tag, "_busy_rise"}, busy, 1'b1);
    chk({tag, "_sum_clr"}, sum, '0);
    cyc = 0;
    while (!done && cyc < W + 6) begin
      start = (cyc == ign);
      a = W'($urandom); b = W'($urandom);
`ifdef SERIAL_SUB_EN
      sub = 1'($urandom);
`endif
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cyc, W);
    chk({tag, "_sum"}, sum, exp[W-1:0]);
    chk({tag, "_cout"}, cout, exp[W]);
    @(negedge clk);
    chk({tag, "_done_fall"}, done, 1'b0);
    chk({tag, "_busy_fall"}, busy, 1'b0);
    chk({tag, "_sum_hold"}, sum, exp[W-1:0]);
  endtask

  initial begin
    logic [W:0] exp;
    int t;
    int np;
    int last;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", cout, 1'b0);

    // Directed add with hold check
    do_op("d5a3c", 8'h5A, 8'h3C, 1'b0, -1);
    chk("d5a3c_const", sum, 8'h96);
    repeat (9) @(negedge clk);
    chk("hold_sum", sum, 8'h96);
    chk("hold_cout", cout, 1'b0);
    chk("hold_busy", busy, 1'b0);

    // Overflow case
    do_op("dff01", 8'hFF, 8'h01, 1'b0, -1);
    chk("dff01_const", {cout, sum}, 9'h100);

    // Start held high: done every W+2 cycles
    exp = model(8'hC7, 8'h6B, 1'b0);
    @(negedge clk);
    a = 8'hC7; b = 8'h6B; sub = 1'b0; start = 1'b1;
    t = 0; np = 0; last = 0;
    while (np < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (done) begin
        if (np == 0) chk("held_first", t, W + 1);
        else         chk("held_period", t - last, W + 2);
        chk("held_sum", {cout, sum}, exp);
        last = t;
        np++;
      end
    end
    if (np < 3) chk("held_timeout", np, 3);
    start = 1'b0;
    t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("held_idle", busy, 1'b0);

    // Stray start during SHIFT is ignored
    do_op("ignore", 8'h33, 8'h44, 1'b0, 3);
    chk("ignore_const", sum, 8'h77);

    // Asynchronous reset between edges during bit processing
    @(negedge clk);
    a = 8'hFF; b = 8'h00; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_sum", sum, '0);
    chk("arst_cout", cout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    do_op("after_rst", 8'h01, 8'h02, 1'b0, -1);
    chk("after_rst_const", sum, 8'h03);

`ifdef SERIAL_SUB_EN
    do_op("sub1020", 8'h10, 8'h20, 1'b1, -1);
    chk("sub1020_const", {cout, sum}, 9'h0F0);
    do_op("sub2010", 8'h20, 8'h10, 1'b1, -1);
    chk("sub2010_const", {cout, sum}, 9'h110);
`endif

    // Randomized operations with random idle gaps
    for (int i = 0; i < 25; i++) begin
      logic s;
      s = 1'b0;
`ifdef SERIAL_SUB_EN
      s = 1'($urandom);
`endif
      do_op("rand", W'($urandom), W'($urandom), s, (i % 3 == 0) ? int'($urandom_range(0, W - 1)) : -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
